lzx_cmp16_seq: RTL
==================

LZX_CMP16_SEQ -- requirements
Module: lzx_cmp16_seq

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning):
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_n  input  1  asynchronous, active-low reset.
REQ-004 START  input  1  request a compare; sampled on rising CLK edges only.
REQ-005 A  input  16  operand A, unsigned, sampled only on an accepted START.
REQ-006 B  input  16  operand B, unsigned, sampled only on an accepted START.
REQ-007 IA_g, IA_e, IA_l  input  1 each  cascade-in result from a lower-order word, sampled only on an accepted START.
REQ-008 BUSY  output  1  high while a compare is in progress.
REQ-009 DONE  output  1  one-cycle pulse when a new result is presented.
REQ-010 QA_g, QA_e, QA_l  output  1 each  registered result: A>B, A=B, A<B; at most one high.

Function
REQ-011 SHALL use FSM states IDLE and RUN and a 2-bit nibble counter CNT.
REQ-012 START is accepted only in IDLE: the accepting edge latches A, B, sets CNT=0, sets BUSY=1, and enters RUN.
REQ-013 The accepting edge SHALL set the running relation REL from cascade-in with priority IA_g>IA_l>IA_e: G, L or E; if all three are 0, REL=NONE.
REQ-014 In RUN, each edge SHALL compare nibble CNT (CNT=0 is bits 3:0 ... CNT=3 is bits 15:12) of latched A vs latched B, then increment CNT.
REQ-015 Per nibble: A nibble > B nibble gives REL=G; A nibble < B nibble gives REL=L; equal nibbles leave REL unchanged. Higher nibbles processed later therefore dominate.
REQ-016 On the edge processing CNT=3, SHALL load QA_g/QA_e/QA_l from the final REL (NONE gives all three 0), set DONE=1, set BUSY=0, and return to IDLE.
REQ-017 Latency: START accepted at edge k gives result and DONE visible after edge k+4; a new START can be accepted at edge k+5.
REQ-018 DONE SHALL be high for exactly one cycle per completed compare and low otherwise.
REQ-019 QA outputs SHALL hold the previous result throughout RUN and IDLE until the next completion edge.
REQ-020 START while BUSY=1 SHALL be ignored, with no effect on operands, REL, CNT or outputs.
REQ-021 START high in the cycle DONE=1 (FSM in IDLE) SHALL be accepted.
REQ-022 START held high continuously SHALL give back-to-back compares every 5 cycles.
REQ-023 A, B and IA_* changing during RUN SHALL NOT affect the in-flight result.
REQ-024 The cascade-in value SHALL decide the result only when all four nibble pairs are equal.

Reset
REQ-025 RST_n=0 SHALL immediately force IDLE, CNT=0, REL=NONE, BUSY=0, DONE=0, QA_g=QA_e=QA_l=0, independent of CLK.
REQ-026 Reset asserted during RUN SHALL abort the compare: no DONE pulse and no result update after release.
REQ-027 After RST_n rises, the first rising edge with START=1 SHALL be accepted normally.

Verification
REQ-028 A=0x1234, B=0x1234, IA_e=1 -> after 4 edges DONE=1, QA_e=1, QA_g=QA_l=0.
REQ-029 A=0x8000, B=0x7FFF, IA_l=1 -> QA_g=1 (top nibble dominates). A=0x1230, B=0x1231, IA_g=1 -> QA_l=1 (nibble difference overrides cascade-in).
REQ-030 A=B=0xABCD: IA_g=1 -> QA_g=1; IA_g=IA_l=1 -> QA_g=1; all IA_*=0 -> QA_g=QA_e=QA_l=0 with DONE still pulsed.
REQ-031 START accepted, START re-pulsed with A=0x0000/B=0xFFFF at edges k+1..k+3 -> first result unaffected, exactly one DONE; START held high -> DONE at k+4, k+9, k+14.
REQ-032 RST_n low between edges k+2 and k+3 -> all outputs 0 asynchronously; no DONE afterward; next START completes normally 4 edges later.

Source files
------------

// File: rtl/lzx_cmp16_seq.sv
// lzx_cmp16_seq: sequential 16-bit magnitude comparator with cascade input.
// Walks the latched operands one nibble per cycle, LSB nibble first, so the
// most significant differing nibble is the last to write the running
// relation and therefore decides the result. The cascade-in value only
// survives when every nibble pair is equal.
module lzx_cmp16_seq (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        START,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        IA_g,
    input  logic        IA_e,
    input  logic        IA_l,
    output logic        BUSY,
    output logic        DONE,
    output logic        QA_g,
    output logic        QA_e,
    output logic        QA_l
);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {REL_NONE, REL_G, REL_L, REL_E} rel_t;

    state_t      state, state_nxt;
    rel_t        rel, rel_nxt;
    rel_t        rel_cas, rel_step;
    logic [1:0]  cnt, cnt_nxt;
    logic [15:0] a_q, a_nxt;
    logic [15:0] b_q, b_nxt;
    logic        done_q, done_nxt;
    logic [2:0]  qa, qa_nxt;
    logic [3:0]  a_nib, b_nib;

    // Cascade-in decode, greater wins over less wins over equal.
    always_comb begin
        rel_cas = REL_NONE;
        if (IA_g)      rel_cas = REL_G;
        else if (IA_l) rel_cas = REL_L;
        else if (IA_e) rel_cas = REL_E;
    end

    // One nibble step: a differing nibble overwrites the relation, an equal
    // nibble leaves whatever the lower nibbles (or cascade-in) decided.
    always_comb begin
        a_nib    = a_q[{cnt, 2'b00} +: 4];
        b_nib    = b_q[{cnt, 2'b00} +: 4];
        rel_step = rel;
        if (a_nib > b_nib)      rel_step = REL_G;
        else if (a_nib < b_nib) rel_step = REL_L;
    end

    // FSM next-state and datapath next values.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rel_nxt   = rel;
        a_nxt     = a_q;
        b_nxt     = b_q;
        done_nxt  = 1'b0;
        qa_nxt    = qa;
        case (state)
            IDLE: begin
                if (START) begin
                    a_nxt     = A;
                    b_nxt     = B;
                    cnt_nxt   = 2'd0;
                    rel_nxt   = rel_cas;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                rel_nxt = rel_step;
                cnt_nxt = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                    case (rel_step)
                        REL_G:   qa_nxt = 3'b100;
                        REL_E:   qa_nxt = 3'b010;
                        REL_L:   qa_nxt = 3'b001;
                        default: qa_nxt = 3'b000;
                    endcase
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            rel    <= REL_NONE;
            a_q    <= 16'd0;
            b_q    <= 16'd0;
            done_q <= 1'b0;
            qa     <= 3'b000;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rel    <= rel_nxt;
            a_q    <= a_nxt;
            b_q    <= b_nxt;
            done_q <= done_nxt;
            qa     <= qa_nxt;
        end
    end

    assign BUSY = (state == RUN);
    assign DONE = done_q;
    assign {QA_g, QA_e, QA_l} = qa;

endmodule
